tlu_event_packer: RTL and testbench

Downstream consumer of the TLU master's 16-bit event FIFO port. Reads each 8-word (128-bit) trigger event, packs it into framed 32-bit words (header, four data words, trailer) and presents them on a valid/ready stream toward the readout arbiter. Back-pressure from the stream stalls FIFO reads without losing or duplicating words. Runs entirely in the bus clock domain.

---
 rtl/tlu_event_packer.sv | 86 ++++++++
 tb/tb_tlu_event_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tlu_event_packer.sv
// tlu_event_packer: frames 8-word TLU FIFO events as header, 4 data words and trailer on a 32-bit valid/ready stream.
// Define TLU_PACKER_CHECKSUM_EN to carry the XOR of the 8 payload words in the trailer low half.
module tlu_event_packer #(
    parameter logic [7:0] HEADER_ID  = 8'hE7,
    parameter logic [7:0] TRAILER_ID = 8'h7E
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic        ENABLE,
    input  logic        FIFO_EMPTY,
    input  logic [15:0] FIFO_DATA,
    output logic        FIFO_READ,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    output logic        OUT_LAST,
    input  logic        OUT_READY,
    output logic [7:0]  EVT_SEQ,
    output logic [15:0] EVENT_CNT,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, LO, HI, TRL} state_t;
    state_t      state;
    logic [1:0]  pc;
    logic [15:0] lo;
    logic [15:0] csum;
    logic        load_ok;
    assign load_ok   = !OUT_VALID | OUT_READY;
    assign FIFO_READ = (state == LO) | ((state == HI) & load_ok);
    assign BUSY      = (state != IDLE) | OUT_VALID;
`ifdef TLU_PACKER_CHECKSUM_EN
    logic [15:0] xs;
    assign csum = xs;
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
        if (!BUS_RST_N) xs <= '0;
        else if (state == IDLE) xs <= '0;
        else if (FIFO_READ) xs <= xs ^ FIFO_DATA;
`else
    assign csum = 16'h0000;
`endif
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state     <= IDLE;
            pc        <= '0;
            lo        <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            EVT_SEQ   <= '0;
            EVENT_CNT <= '0;
        end else begin
            if (OUT_READY) begin
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
            end
            case (state)
                IDLE: if (ENABLE & !FIFO_EMPTY & load_ok) begin
                    OUT_DATA  <= {HEADER_ID, EVT_SEQ, 16'd8};
                    OUT_VALID <= 1'b1;
                    OUT_LAST  <= 1'b0;
                    pc        <= '0;
                    state     <= LO;
                end
                LO: begin
                    lo    <= FIFO_DATA;
                    state <= HI;
                end
                HI: if (load_ok) begin
                    OUT_DATA  <= {FIFO_DATA, lo};
                    OUT_VALID <= 1'b1;
                    OUT_LAST  <= 1'b0;
                    pc        <= pc + 2'd1;
                    state     <= (pc == 2'd3) ? TRL : LO;
                end
                TRL: if (load_ok) begin
                    OUT_DATA  <= {TRAILER_ID, EVT_SEQ, csum};
                    OUT_VALID <= 1'b1;
                    OUT_LAST  <= 1'b1;
                    EVT_SEQ   <= EVT_SEQ + 8'd1;
                    EVENT_CNT <= EVENT_CNT + 16'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlu_event_packer.sv
// tb_tlu_event_packer: directed bench with a show-ahead FIFO model and a stream capture monitor.
module tb_tlu_event_packer;
    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        OUT_READY = 1'b1;
    logic        FIFO_EMPTY, FIFO_READ, OUT_VALID, OUT_LAST, BUSY;
    logic [15:0] FIFO_DATA, EVENT_CNT;
    logic [31:0] OUT_DATA;
    logic [7:0]  EVT_SEQ;
    logic [15:0] mem [4096];
    logic [31:0] cap_data [4096];
    logic        cap_last [4096];
    int rd = 0, wr = 0, nreads = 0, ncap = 0;
    int compared = 0, mismatched = 0;

    tlu_event_packer dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_READ(FIFO_READ),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY), .EVT_SEQ(EVT_SEQ), .EVENT_CNT(EVENT_CNT), .BUSY(BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;
    assign FIFO_EMPTY = (rd == wr);
    assign FIFO_DATA  = mem[rd];

    // FIFO pop/flush and capture of every accepted stream word
    always @(posedge BUS_CLK) begin
        if (!BUS_RST_N) rd <= wr;
        else if (FIFO_READ) begin
            rd     <= rd + 1;
            nreads <= nreads + 1;
        end
        if (BUS_RST_N && OUT_VALID && OUT_READY) begin
            cap_data[ncap] <= OUT_DATA;
            cap_last[ncap] <= OUT_LAST;
            ncap           <= ncap + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_evt(input logic [7:0] tag);
        for (int i = 0; i < 8; i++) mem[wr + i] = {tag, 8'(i + 1)};
        wr = wr + 8;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int t;
        t = 0;
        while (ncap < n && t < budget) begin
            @(negedge BUS_CLK);
            t++;
        end
        chk("wait_caps", 32'(ncap >= n), 32'd1);
    endtask

    task automatic check_evt(input int idx, input logic [7:0] seq, input logic [7:0] tag);
        logic [15:0] w [8];
        logic [31:0] e [6];
        logic [15:0] cs;
        cs = '0;
        for (int i = 0; i < 8; i++) begin
            w[i] = {tag, 8'(i + 1)};
            cs   = cs ^ w[i];
        end
`ifndef TLU_PACKER_CHECKSUM_EN
        cs = 16'h0000;
`endif
        e[0] = {8'hE7, seq, 16'h0008};
        for (int k = 0; k < 4; k++) e[k + 1] = {w[2 * k + 1], w[2 * k]};
        e[5] = {8'h7E, seq, cs};
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("seq%0d_w%0d_data", seq, k), cap_data[idx + k], e[k]);
            chk($sformatf("seq%0d_w%0d_last", seq, k), 32'(cap_last[idx + k]), 32'(k == 5));
        end
    endtask

    initial begin
        int base, r0, t;
        logic [31:0] d0;
        logic v0;
        repeat (3) @(negedge BUS_CLK);
        chk("rst_fifo_read", 32'(FIFO_READ), 32'd0);
        chk("rst_out_data", OUT_DATA, 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_last", 32'(OUT_LAST), 32'd0);
        chk("rst_evt_seq", 32'(EVT_SEQ), 32'd0);
        chk("rst_event_cnt", 32'(EVENT_CNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        BUS_RST_N = 1'b1;
        ENABLE    = 1'b1;
        @(negedge BUS_CLK);

        // single event, sink always ready
        base = ncap; r0 = nreads;
        push_evt(8'h00);
        wait_caps(base + 6, 40);
        check_evt(base, 8'd0, 8'h00);
        chk("s1_evt_seq", 32'(EVT_SEQ), 32'd1);
        chk("s1_event_cnt", 32'(EVENT_CNT), 32'd1);
        chk("s1_reads", nreads - r0, 32'd8);
        chk("s1_busy", 32'(BUSY), 32'd0);

        // same event under back-pressure: 5 stalled cycles per accept slot
        base = ncap; r0 = nreads;
        push_evt(8'h00);
        for (int it = 0; it < 30 && ncap < base + 6; it++) begin
            OUT_READY = 1'b0;
            v0 = OUT_VALID;
            d0 = OUT_DATA;
            repeat (5) begin
                @(negedge BUS_CLK);
                if (v0) chk("s2_hold", OUT_DATA, d0);
            end
            OUT_READY = 1'b1;
            @(negedge BUS_CLK);
        end
        wait_caps(base + 6, 5);
        check_evt(base, 8'd1, 8'h00);
        chk("s2_reads", nreads - r0, 32'd8);
        chk("s2_event_cnt", 32'(EVENT_CNT), 32'd2);

        // ENABLE dropped after the first header with a second event queued
        base = ncap;
        push_evt(8'h31);
        push_evt(8'h32);
        t = 0;
        while (!OUT_VALID && t < 20) begin
            @(negedge BUS_CLK);
            t++;
        end
        chk("s3_hdr_seen", 32'(OUT_VALID), 32'd1);
        ENABLE = 1'b0;
        wait_caps(base + 6, 40);
        check_evt(base, 8'd2, 8'h31);
        repeat (20) @(negedge BUS_CLK);
        chk("s3_no_hdr", ncap, base + 6);
        chk("s3_busy", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;
        wait_caps(base + 12, 40);
        check_evt(base + 6, 8'd3, 8'h32);
        chk("s3_event_cnt", 32'(EVENT_CNT), 32'd4);

        // reset while in HI with pc=2 (five words read)
        r0 = nreads;
        push_evt(8'h44);
        t = 0;
        while (nreads - r0 < 5 && t < 20) begin
            @(negedge BUS_CLK);
            t++;
        end
        chk("s4_reads", nreads - r0, 32'd5);
        chk("s4_busy_pre", 32'(BUSY), 32'd1);
        BUS_RST_N = 1'b0;
        #1;
        chk("s4_fifo_read", 32'(FIFO_READ), 32'd0);
        chk("s4_out_data", OUT_DATA, 32'd0);
        chk("s4_out_valid", 32'(OUT_VALID), 32'd0);
        chk("s4_out_last", 32'(OUT_LAST), 32'd0);
        chk("s4_evt_seq", 32'(EVT_SEQ), 32'd0);
        chk("s4_event_cnt", 32'(EVENT_CNT), 32'd0);
        chk("s4_busy", 32'(BUSY), 32'd0);
        repeat (2) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        @(negedge BUS_CLK);
        base = ncap;
        push_evt(8'h55);
        wait_caps(base + 6, 40);
        check_evt(base, 8'd0, 8'h55);
        chk("s4_event_cnt_after", 32'(EVENT_CNT), 32'd1);

        // 256 back-to-back events, then the wrap on event 257
        BUS_RST_N = 1'b0;
        repeat (2) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        @(negedge BUS_CLK);
        base = ncap; r0 = nreads;
        for (int e = 0; e < 256; e++) push_evt(8'(e));
        wait_caps(base + 256 * 6, 256 * 12 + 50);
        for (int e = 0; e < 256; e++) check_evt(base + 6 * e, 8'(e), 8'(e));
        chk("s5_event_cnt", 32'(EVENT_CNT), 32'd256);
        chk("s5_evt_seq", 32'(EVT_SEQ), 32'd0);
        chk("s5_reads", nreads - r0, 32'd2048);
        push_evt(8'hA5);
        wait_caps(base + 257 * 6, 40);
        check_evt(base + 256 * 6, 8'd0, 8'hA5);
        chk("s5_event_cnt_257", 32'(EVENT_CNT), 32'd257);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
